id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage that sits directly upstream of the execute ALU.
- Registers a decoded instruction and detects load-use hazards.
- Applies EX/MEM and MEM/WB operand forwarding, then presents operation select and operands to the ALU with a valid/ready handshake.
- Also supports flush on branch redirect and keeps a saturating stall counter for performance monitoring.

Parameters:
XLEN, 32, datapath and operand width
SEL_W, 5, ALU operation selector width (matches ALU sel encoding 0..9)
RA_W, 5, register address width
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode offers an instruction
id_ready  out  1  stage accepts the instruction this cycle
id_alu_sel  in  SEL_W  ALU operation code
id_rs1, id_rs2  in  RA_W  source register addresses
id_rs1_data, id_rs2_data  in  XLEN  register-file read data
id_imm  in  XLEN  sign-extended immediate
id_use_imm  in  1  operand 2 comes from id_imm
id_rd  in  RA_W  destination register
id_reg_write  in  1  instruction writes rd
id_mem_read  in  1  instruction is a load
flush  in  1  synchronous kill of the held and the incoming instruction
exm_rd, mwb_rd  in  RA_W  destination address in EX/MEM and MEM/WB
exm_reg_write, mwb_reg_write  in  1  write enables of those stages
exm_result, mwb_result  in  XLEN  forwardable results
ex_valid  out  1  ALU inputs hold a real instruction
ex_ready  in  1  downstream consumes the instruction this cycle
ex_alu_sel  out  SEL_W  to ALU sel
ex_data1, ex_data2  out  XLEN  forwarded operands to ALU
ex_rd  out  RA_W  destination, passed through
ex_reg_write, ex_mem_read  out  1  control, passed through
stall_cnt  out  CNT_W  saturating count of load-use bubble cycles

Behaviour:
- Reset (async on rst_n low):
  - All stored fields clear to 0: ex_valid=0, stall_cnt=0.
  - Combinational outputs therefore read 0: ex_alu_sel=0, ex_data1=0, ex_data2=0, ex_rd=0.
- Stored fields: valid, alu_sel, rs1, rs2, rs1_data, rs2_data, imm, use_imm, rd, reg_write, mem_read.
- Load-use hazard (combinational):
  - hz = valid & mem_read & (rd!=0) & ((rd==id_rs1) | (rd==id_rs2 & !id_use_imm)).
  - hz is evaluated regardless of id_valid.
- id_ready = !flush & !hz & (!valid | ex_ready).
- Capture: when id_valid & id_ready, all fields load from id_* and valid<=1. Latency 1 cycle, ID to ALU inputs.
- Drain: if valid & ex_ready and there is no capture, valid<=0.
- Hold: if valid & !ex_ready, all fields hold and id_ready=0.
- Bubble: if hz & id_valid & ex_ready:
  - valid<=0, so the load leaves and a bubble is inserted.
  - The decode instruction is retried next cycle.
  - stall_cnt increments, saturating at all-ones.
  - If hz & !ex_ready, this is an ordinary hold and no count.
- Flush: highest priority. valid<=0 next edge, and no capture that cycle (id_ready=0). Overrides hold and bubble. No stall count.
- Forwarding (combinational on stored operands):
  - Operand 1: if exm_reg_write & exm_rd!=0 & exm_rd==rs1 then exm_result; else if mwb_reg_write & mwb_rd!=0 & mwb_rd==rs1 then mwb_result; else rs1_data.
  - EX/MEM has priority over MEM/WB.
  - Operand 2: use_imm ? imm : same forwarding rule on rs2.
  - Register x0 is never forwarded.
- ex_alu_sel, ex_rd, ex_reg_write, ex_mem_read come from stored fields.
- When valid=0, outputs still show the stored fields; only ex_valid qualifies them.
- Pass-through widths unchanged; no arithmetic in this block.

Test Plan:
1. Reset with rst_n=0 mid-transfer (valid=1) -> ex_valid=0 and stall_cnt=0 immediately, before the clock edge; ex_data1=ex_data2=0.
2. Capture add (sel=0, rs1=3 data 5, rs2=4 data 7), ex_ready=1, no forwarding -> next cycle ex_valid=1, ex_alu_sel=0, ex_data1=5, ex_data2=7.
3. Stored rs1=3, exm_rd=3 exm_reg_write=1 exm_result=0x10, mwb_rd=3 mwb_result=0x20 -> ex_data1=0x10. Repeat with rs1=0 and exm_rd=0 -> stored rs1_data.
4. Stored load rd=6, id_valid=1 id_rs1=6, ex_ready=1 -> id_ready=0, next cycle ex_valid=0 and stall_cnt=1; following cycle instruction captured. Same with id_use_imm=1 and id_rs2=6 only -> no stall.
5. ex_ready=0 for 3 cycles with valid=1 -> all outputs stable, id_ready=0, stall_cnt unchanged. Then ex_ready=1 with id_valid=0 -> ex_valid=0.
6. flush=1 while valid=1, ex_ready=0, id_valid=1 -> id_ready=0 and ex_valid=0 next cycle. stall_cnt at 0xFFFF plus another bubble -> stays 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// Decode-side and ALU-side signals of the ID/EX stage.
// The forwarding sources from EX/MEM and MEM/WB are carried here as well.
interface id_ex_stage_if #(
    parameter int XLEN  = 32,
    parameter int SEL_W = 5,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic             id_ready;
    logic [SEL_W-1:0] id_alu_sel;
    logic [RA_W-1:0]  id_rs1;
    logic [RA_W-1:0]  id_rs2;
    logic [XLEN-1:0]  id_rs1_data;
    logic [XLEN-1:0]  id_rs2_data;
    logic [XLEN-1:0]  id_imm;
    logic             id_use_imm;
    logic [RA_W-1:0]  id_rd;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             flush;
    logic [RA_W-1:0]  exm_rd;
    logic [RA_W-1:0]  mwb_rd;
    logic             exm_reg_write;
    logic             mwb_reg_write;
    logic [XLEN-1:0]  exm_result;
    logic [XLEN-1:0]  mwb_result;
    logic             ex_valid;
    logic             ex_ready;
    logic [SEL_W-1:0] ex_alu_sel;
    logic [XLEN-1:0]  ex_data1;
    logic [XLEN-1:0]  ex_data2;
    logic [RA_W-1:0]  ex_rd;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_alu_sel, id_rs1, id_rs2, id_rs1_data, id_rs2_data,
               id_imm, id_use_imm, id_rd, id_reg_write, id_mem_read, flush,
               exm_rd, mwb_rd, exm_reg_write, mwb_reg_write, exm_result,
               mwb_result, ex_ready,
        input  id_ready, ex_valid, ex_alu_sel, ex_data1, ex_data2, ex_rd,
               ex_reg_write, ex_mem_read, stall_cnt
    );

    modport slave (
        input  id_valid, id_alu_sel, id_rs1, id_rs2, id_rs1_data, id_rs2_data,
               id_imm, id_use_imm, id_rd, id_reg_write, id_mem_read, flush,
               exm_rd, mwb_rd, exm_reg_write, mwb_reg_write, exm_result,
               mwb_result, ex_ready,
        output id_ready, ex_valid, ex_alu_sel, ex_data1, ex_data2, ex_rd,
               ex_reg_write, ex_mem_read, stall_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX register stage: load-use bubble insertion, EX/MEM + MEM/WB operand
// forwarding, valid/ready handoff to the ALU, saturating bubble counter.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int SEL_W = 5,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    id_ex_stage_if.slave  bus
);
    typedef struct packed {
        logic [SEL_W-1:0] alu_sel;
        logic [RA_W-1:0]  rs1;
        logic [RA_W-1:0]  rs2;
        logic [XLEN-1:0]  rs1_data;
        logic [XLEN-1:0]  rs2_data;
        logic [XLEN-1:0]  imm;
        logic             use_imm;
        logic [RA_W-1:0]  rd;
        logic             reg_write;
        logic             mem_read;
    } fields_t;

    fields_t          fld_q, fld_d, fld_in;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             hz, capture, bubble;

    // EX/MEM wins over MEM/WB; x0 is never forwarded.
    function automatic logic [XLEN-1:0] fwd(
        input logic [RA_W-1:0] rs,
        input logic [XLEN-1:0] rf_data,
        input logic            exm_we,
        input logic [RA_W-1:0] exm_rd,
        input logic [XLEN-1:0] exm_res,
        input logic            mwb_we,
        input logic [RA_W-1:0] mwb_rd,
        input logic [XLEN-1:0] mwb_res
    );
        if (exm_we && exm_rd != '0 && exm_rd == rs)      return exm_res;
        else if (mwb_we && mwb_rd != '0 && mwb_rd == rs) return mwb_res;
        else                                             return rf_data;
    endfunction

    assign fld_in = '{
        alu_sel:   bus.id_alu_sel,
        rs1:       bus.id_rs1,
        rs2:       bus.id_rs2,
        rs1_data:  bus.id_rs1_data,
        rs2_data:  bus.id_rs2_data,
        imm:       bus.id_imm,
        use_imm:   bus.id_use_imm,
        rd:        bus.id_rd,
        reg_write: bus.id_reg_write,
        mem_read:  bus.id_mem_read
    };

    // Hazard is checked against whatever decode presents, valid or not.
    assign hz = valid_q & fld_q.mem_read & (fld_q.rd != '0) &
                ((fld_q.rd == bus.id_rs1) | ((fld_q.rd == bus.id_rs2) & ~bus.id_use_imm));

    assign bus.id_ready = ~bus.flush & ~hz & (~valid_q | bus.ex_ready);
    assign capture      = bus.id_valid & bus.id_ready;
    assign bubble       = hz & bus.id_valid & bus.ex_ready & ~bus.flush;

    always_comb begin
        fld_d       = fld_q;
        valid_d     = valid_q;
        stall_cnt_d = stall_cnt_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d = 1'b1;
            fld_d   = fld_in;
        end else if (valid_q && bus.ex_ready) begin
            valid_d = 1'b0;
        end
        if (bubble && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fld_q       <= '0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            fld_q       <= fld_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.ex_valid     = valid_q;
    assign bus.ex_alu_sel   = fld_q.alu_sel;
    assign bus.ex_rd        = fld_q.rd;
    assign bus.ex_reg_write = fld_q.reg_write;
    assign bus.ex_mem_read  = fld_q.mem_read;
    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.ex_data1     = fwd(fld_q.rs1, fld_q.rs1_data,
                                  bus.exm_reg_write, bus.exm_rd, bus.exm_result,
                                  bus.mwb_reg_write, bus.mwb_rd, bus.mwb_result);
    assign bus.ex_data2     = fld_q.use_imm ? fld_q.imm :
                              fwd(fld_q.rs2, fld_q.rs2_data,
                                  bus.exm_reg_write, bus.exm_rd, bus.exm_result,
                                  bus.mwb_reg_write, bus.mwb_rd, bus.mwb_result);
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed checks on handshake/hazard/flush/counter,
// plus a scoreboard comparing every presented ALU instruction to a model.
module tb_id_ex_stage;
    localparam int XLEN  = 32;
    localparam int SEL_W = 5;
    localparam int RA_W  = 5;
    // Narrow counter so saturation is reachable in a short run.
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    id_ex_stage_if #(.XLEN(XLEN), .SEL_W(SEL_W), .RA_W(RA_W), .CNT_W(CNT_W)) bus();

    id_ex_stage #(.XLEN(XLEN), .SEL_W(SEL_W), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [SEL_W-1:0] sel;
        logic [RA_W-1:0]  rs1, rs2, rd;
        logic [XLEN-1:0]  d1, d2, imm;
        logic             use_imm, rw, mr;
    } txn_t;

    txn_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] ref_fwd(input logic [RA_W-1:0] rs, input logic [XLEN-1:0] rf);
        if (bus.exm_reg_write && bus.exm_rd != 0 && bus.exm_rd == rs) return bus.exm_result;
        if (bus.mwb_reg_write && bus.mwb_rd != 0 && bus.mwb_rd == rs) return bus.mwb_result;
        return rf;
    endfunction

    // Scoreboard: compare head while presented, pop on consume/flush, push on accept.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (bus.ex_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'(sb.size()), 64'd1);
                end else begin
                    chk("sb_sel", 64'(bus.ex_alu_sel), 64'(sb[0].sel));
                    chk("sb_d1",  64'(bus.ex_data1), 64'(ref_fwd(sb[0].rs1, sb[0].d1)));
                    chk("sb_d2",  64'(bus.ex_data2),
                        64'(sb[0].use_imm ? sb[0].imm : ref_fwd(sb[0].rs2, sb[0].d2)));
                    chk("sb_rd",  64'(bus.ex_rd), 64'(sb[0].rd));
                    chk("sb_rw",  64'(bus.ex_reg_write), 64'(sb[0].rw));
                    chk("sb_mr",  64'(bus.ex_mem_read), 64'(sb[0].mr));
                    if (bus.ex_ready || bus.flush) void'(sb.pop_front());
                end
            end
            if (bus.id_valid && bus.id_ready) begin
                sb.push_back('{sel: bus.id_alu_sel, rs1: bus.id_rs1, rs2: bus.id_rs2,
                               rd: bus.id_rd, d1: bus.id_rs1_data, d2: bus.id_rs2_data,
                               imm: bus.id_imm, use_imm: bus.id_use_imm,
                               rw: bus.id_reg_write, mr: bus.id_mem_read});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_idle();
        bus.id_valid     = 1'b0;
        bus.id_alu_sel   = '0;
        bus.id_rs1       = '0;
        bus.id_rs2       = '0;
        bus.id_rs1_data  = '0;
        bus.id_rs2_data  = '0;
        bus.id_imm       = '0;
        bus.id_use_imm   = 1'b0;
        bus.id_rd        = '0;
        bus.id_reg_write = 1'b0;
        bus.id_mem_read  = 1'b0;
    endtask

    task automatic offer(input logic [SEL_W-1:0] sel, input logic [RA_W-1:0] rs1,
                         input logic [XLEN-1:0] d1, input logic [RA_W-1:0] rs2,
                         input logic [XLEN-1:0] d2, input logic [XLEN-1:0] imm,
                         input logic use_imm, input logic [RA_W-1:0] rd,
                         input logic rw, input logic mr);
        bus.id_valid     = 1'b1;
        bus.id_alu_sel   = sel;
        bus.id_rs1       = rs1;
        bus.id_rs1_data  = d1;
        bus.id_rs2       = rs2;
        bus.id_rs2_data  = d2;
        bus.id_imm       = imm;
        bus.id_use_imm   = use_imm;
        bus.id_rd        = rd;
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
    endtask

    task automatic fwd_set(input logic ew, input logic [RA_W-1:0] erd, input logic [XLEN-1:0] eres,
                           input logic mw, input logic [RA_W-1:0] mrd, input logic [XLEN-1:0] mres);
        bus.exm_reg_write = ew;
        bus.exm_rd        = erd;
        bus.exm_result    = eres;
        bus.mwb_reg_write = mw;
        bus.mwb_rd        = mrd;
        bus.mwb_result    = mres;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        set_idle();
        fwd_set(0, 0, 0, 0, 0, 0);
        bus.ex_ready = 1'b1;
        bus.flush    = 1'b0;
        #3;
        chk("rst_valid", 64'(bus.ex_valid), 64'd0);
        chk("rst_cnt",   64'(bus.stall_cnt), 64'd0);
        chk("rst_d1",    64'(bus.ex_data1), 64'd0);
        chk("rst_d2",    64'(bus.ex_data2), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Plain capture, 1-cycle latency
        offer(0, 3, 5, 4, 7, 0, 0, 8, 1, 0);
        smp(); chk("cap_id_ready", 64'(bus.id_ready), 64'd1);
        step(); set_idle(); bus.ex_ready = 1'b0;
        smp();
        chk("cap_valid", 64'(bus.ex_valid), 64'd1);
        chk("cap_sel",   64'(bus.ex_alu_sel), 64'd0);
        chk("cap_d1",    64'(bus.ex_data1), 64'd5);
        chk("cap_d2",    64'(bus.ex_data2), 64'd7);

        // Forwarding while held
        step(); fwd_set(1, 3, 'h10, 1, 3, 'h20);
        smp(); chk("fwd_exm_prio", 64'(bus.ex_data1), 64'h10);
        step(); fwd_set(0, 3, 'h10, 1, 3, 'h20);
        smp(); chk("fwd_mwb", 64'(bus.ex_data1), 64'h20);
        step(); fwd_set(1, 4, 'h30, 0, 0, 0);
        smp(); chk("fwd_rs2", 64'(bus.ex_data2), 64'h30);
        step(); fwd_set(0, 0, 0, 0, 0, 0); bus.ex_ready = 1'b1;
        smp();
        step(); smp(); chk("drain_valid", 64'(bus.ex_valid), 64'd0);

        // x0 never forwarded
        step(); fwd_set(1, 0, 'h10, 1, 0, 'h20); offer(1, 0, 'h55, 0, 'h66, 0, 0, 9, 1, 0);
        smp();
        step(); set_idle(); smp();
        chk("x0_d1", 64'(bus.ex_data1), 64'h55);
        chk("x0_d2", 64'(bus.ex_data2), 64'h66);

        // Load-use bubble
        step(); fwd_set(0, 0, 0, 0, 0, 0); offer(0, 1, 'h100, 2, 0, 4, 1, 6, 1, 1);
        smp();
        step(); offer(2, 6, 0, 0, 0, 0, 0, 7, 1, 0);
        smp(); chk("hz_id_ready", 64'(bus.id_ready), 64'd0);
        step(); smp();
        chk("bubble_valid", 64'(bus.ex_valid), 64'd0);
        chk("bubble_cnt",   64'(bus.stall_cnt), 64'd1);
        chk("retry_ready",  64'(bus.id_ready), 64'd1);
        step(); offer(0, 1, 0, 2, 0, 4, 1, 6, 1, 1);
        smp(); chk("retry_captured", 64'(bus.ex_valid), 64'd1);
        step(); offer(3, 5, 'h11, 6, 'h22, 'h8, 1, 10, 1, 0);
        smp(); chk("imm_no_hz", 64'(bus.id_ready), 64'd1);
        step(); offer(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        smp();
        step(); offer(4, 0, 'h33, 0, 'h44, 0, 0, 11, 1, 0);
        smp(); chk("rd0_no_hz", 64'(bus.id_ready), 64'd1);
        step(); set_idle();
        smp(); chk("cnt_unchanged", 64'(bus.stall_cnt), 64'd1);

        // Hold with a pending hazard: no count
        step(); offer(5, 6, 'h12, 7, 'h34, 0, 0, 6, 1, 1);
        smp();
        step(); bus.ex_ready = 1'b0; offer(6, 6, 'h1, 6, 'h2, 0, 0, 12, 1, 0);
        smp();
        for (int i = 0; i < 3; i++) begin
            step(); smp();
            chk("hold_ready", 64'(bus.id_ready), 64'd0);
            chk("hold_valid", 64'(bus.ex_valid), 64'd1);
            chk("hold_d1",    64'(bus.ex_data1), 64'h12);
            chk("hold_cnt",   64'(bus.stall_cnt), 64'd1);
        end
        step(); set_idle(); bus.ex_ready = 1'b1;
        smp();
        step(); smp(); chk("hold_release", 64'(bus.ex_valid), 64'd0);

        // Flush over hold
        step(); offer(7, 1, 'h5, 2, 'h6, 0, 0, 13, 1, 0);
        smp();
        step(); bus.ex_ready = 1'b0; offer(8, 1, 'h7, 2, 'h8, 0, 0, 14, 1, 0); bus.flush = 1'b1;
        smp(); chk("flush_ready", 64'(bus.id_ready), 64'd0);
        step(); bus.flush = 1'b0; set_idle();
        smp(); chk("flush_valid", 64'(bus.ex_valid), 64'd0);

        // Flush over bubble: no count
        bus.ex_ready = 1'b1;
        step(); offer(0, 1, 0, 2, 0, 0, 0, 6, 1, 1);
        smp();
        step(); offer(1, 6, 0, 0, 0, 0, 0, 15, 1, 0); bus.flush = 1'b1;
        smp(); chk("flush_hz_ready", 64'(bus.id_ready), 64'd0);
        step(); bus.flush = 1'b0; set_idle();
        smp();
        chk("flush_hz_valid", 64'(bus.ex_valid), 64'd0);
        chk("flush_hz_cnt",   64'(bus.stall_cnt), 64'd1);

        // Self-dependent load stream: one bubble every two cycles
        step(); offer(2, 6, 'h9, 6, 'ha, 0, 0, 6, 1, 1);
        repeat (10) @(posedge clk);
        #1 chk("cnt_mid", 64'(bus.stall_cnt), 64'd6);
        repeat (18) @(posedge clk);
        #1 chk("cnt_sat", 64'(bus.stall_cnt), 64'hF);
        repeat (4) @(posedge clk);
        #1 chk("cnt_sat_hold", 64'(bus.stall_cnt), 64'hF);

        // Async reset mid-transfer
        @(posedge clk);
        #1 set_idle(); bus.ex_ready = 1'b0;
        smp(); chk("pre_rst_valid", 64'(bus.ex_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_valid", 64'(bus.ex_valid), 64'd0);
        chk("mrst_cnt",   64'(bus.stall_cnt), 64'd0);
        chk("mrst_sel",   64'(bus.ex_alu_sel), 64'd0);
        chk("mrst_d1",    64'(bus.ex_data1), 64'd0);
        chk("mrst_d2",    64'(bus.ex_data2), 64'd0);
        chk("mrst_rd",    64'(bus.ex_rd), 64'd0);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
